// File: rtl/button_duty_stepper_if.sv
// Button-to-duty-cycle bundle: raw buttons in, debounced levels and duty level out.
interface button_duty_stepper_if;
  logic       switch1;
  logic       switch2;
  logic       outSwitch1;
  logic       outSwitch2;
  logic [3:0] counter;
  logic [7:0] dutyCycle;
  logic       stepPulse;

  modport master (
    output switch1, switch2,
    input  outSwitch1, outSwitch2, counter, dutyCycle, stepPulse
  );

  modport slave (
    input  switch1, switch2,
    output outSwitch1, outSwitch2, counter, dutyCycle, stepPulse
  );
endinterface

// File: rtl/button_duty_stepper.sv
// Synchronises and debounces up/down buttons and steps a saturating duty level,
// presented both as a 4-bit digit and as an 8-bit percentage.
module button_duty_stepper #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STEP_PCT        = 10,
  parameter int MAX_LEVEL       = 10,
  parameter int RESET_LEVEL     = 5
) (
  input logic                   clk,
  input logic                   rst,
  button_duty_stepper_if.slave  bus
);

  localparam int              CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]      MAX_L     = 4'(MAX_LEVEL);
  localparam logic [3:0]      RESET_L   = 4'(RESET_LEVEL);
  localparam logic [7:0]      STEP      = 8'(STEP_PCT);
  localparam logic [7:0]      RESET_PCT = 8'(RESET_LEVEL * STEP_PCT);

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    fill;
  logic [1:0]    stable;
  logic [1:0]    armed;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  logic [3:0]    level;
  logic [3:0]    level_next;
  logic [7:0]    duty;
  logic          step;

  // fill marks when the synchroniser again carries real samples after reset;
  // armed then requires a released button before any press may count, so a
  // button held through reset never steps.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta   <= '0;
      sync   <= '0;
      fill   <= '0;
      stable <= '0;
      armed  <= '0;
      press  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      meta <= {bus.switch2, bus.switch1};
      sync <= meta;
      fill <= {fill[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (fill[1] && !sync[i]) armed[i] <= 1'b1;
        if (sync[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync[i];
          cnt[i]    <= '0;
          press[i]  <= sync[i] & armed[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path through this block leaves level_next unassigned (no latch).
    level_next = level;
    if (press == 2'b01 && level != MAX_L)
      level_next = level + 4'd1;
    else if (press == 2'b10 && level != 4'd0)
      level_next = level - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= RESET_L;
      duty  <= RESET_PCT;
      step  <= 1'b0;
    end else begin
      level <= level_next;
      duty  <= 8'(level_next) * STEP;
      step  <= (level_next != level);
    end
  end

  assign bus.outSwitch1 = stable[0];
  assign bus.outSwitch2 = stable[1];
  assign bus.counter    = level;
  assign bus.dutyCycle  = duty;
  assign bus.stepPulse  = step;

endmodule

// File: tb/tb_button_duty_stepper.sv
// Self-checking bench: directed scenarios plus random button activity, compared
// every cycle against a window-based behavioural model of the stepper.
module tb_button_duty_stepper;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  button_duty_stepper_if bus();

  button_duty_stepper #(
    .DEBOUNCE_CYCLES(DB),
    .STEP_PCT(10),
    .MAX_LEVEL(10),
    .RESET_LEVEL(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a button's debounced level flips once the last DB
  // synchronised samples all disagree with it; a rising flip is a press only
  // if the button was seen released after reset before that run began.
  int  n = 0;
  bit  hist [2][$];
  bit  m_stable [2];
  int  first_zero [2];
  bit  pend_up, pend_dn;
  int  m_level;
  bit  m_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input bit a, input bit b, input bit r);
    bit prs [2];
    int nl;
    n++;
    if (!r) begin
      m_level = 5;
      m_step  = 0;
      pend_up = 0;
      pend_dn = 0;
      for (int i = 0; i < 2; i++) begin
        m_stable[i]   = 0;
        first_zero[i] = -1;
        hist[i]       = {};
        repeat (DB + 2) hist[i].push_back(1'b0);
      end
      return;
    end
    nl = m_level;
    if (pend_up && !pend_dn && m_level < 10) nl = m_level + 1;
    else if (pend_dn && !pend_up && m_level > 0) nl = m_level - 1;
    m_step  = (nl != m_level);
    m_level = nl;
    for (int i = 0; i < 2; i++) begin
      bit raw, v, all;
      raw    = (i == 0) ? a : b;
      prs[i] = 0;
      v      = hist[i][1];
      all    = 1;
      for (int j = 1; j <= DB; j++) if (hist[i][j] != v) all = 0;
      if (all && v != m_stable[i]) begin
        m_stable[i] = v;
        prs[i] = v && first_zero[i] >= 0 && first_zero[i] <= n - DB - 2;
      end
      hist[i].push_back(raw);
      void'(hist[i].pop_front());
      if (!raw && first_zero[i] < 0) first_zero[i] = n;
    end
    pend_up = prs[0];
    pend_dn = prs[1];
  endtask

  task automatic cyc(input bit a, input bit b, input bit r);
    bus.switch1 = a;
    bus.switch2 = b;
    rst         = r;
    @(posedge clk);
    model_edge(a, b, r);
    #1;
    check("outSwitch1", 32'(bus.outSwitch1), 32'(m_stable[0]));
    check("outSwitch2", 32'(bus.outSwitch2), 32'(m_stable[1]));
    check("counter",    32'(bus.counter),    32'(m_level));
    check("dutyCycle",  32'(bus.dutyCycle),  32'(m_level * 10));
    check("stepPulse",  32'(bus.stepPulse),  32'(m_step));
  endtask

  task automatic hold(input bit a, input bit b, input int cycles);
    repeat (cycles) cyc(a, b, 1'b1);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 6);
  endtask

  initial begin
    int run [2];
    bit val [2];
    bus.switch1 = 1'b0;
    bus.switch2 = 1'b0;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0);
    check("reset_counter", 32'(bus.counter), 32'd5);
    check("reset_duty",    32'(bus.dutyCycle), 32'd50);
    check("reset_step",    32'(bus.stepPulse), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 6);

    // Clean up press held 20 cycles
    hold(1'b1, 1'b0, 20);
    check("up_counter", 32'(bus.counter), 32'd6);
    check("up_duty",    32'(bus.dutyCycle), 32'd60);
    hold(1'b0, 1'b0, 10);

    // Bouncing press then steady
    do_reset();
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 1'b0, 2);
      hold(1'b0, 1'b0, 2);
    end
    check("bounce_nostep", 32'(bus.counter), 32'd5);
    hold(1'b1, 1'b0, 12);
    check("bounce_step", 32'(bus.counter), 32'd6);
    hold(1'b0, 1'b0, 10);

    // Saturation high then low
    do_reset();
    repeat (6) begin
      hold(1'b1, 1'b0, 8);
      hold(1'b0, 1'b0, 8);
    end
    check("sat_hi_counter", 32'(bus.counter), 32'd10);
    check("sat_hi_duty",    32'(bus.dutyCycle), 32'd100);
    repeat (11) begin
      hold(1'b0, 1'b1, 8);
      hold(1'b0, 1'b0, 8);
    end
    check("sat_lo_counter", 32'(bus.counter), 32'd0);
    check("sat_lo_duty",    32'(bus.dutyCycle), 32'd0);

    // Simultaneous presses cancel
    do_reset();
    hold(1'b1, 1'b1, 15);
    check("both_out1",    32'(bus.outSwitch1), 32'd1);
    check("both_out2",    32'(bus.outSwitch2), 32'd1);
    check("both_counter", 32'(bus.counter), 32'd5);
    hold(1'b0, 1'b0, 10);

    // Reset in the middle of a debounce, button still held
    do_reset();
    hold(1'b1, 1'b0, 4);
    cyc(1'b1, 1'b0, 1'b0);
    hold(1'b1, 1'b0, 20);
    check("midrst_held_counter", 32'(bus.counter), 32'd5);
    check("midrst_held_out1",    32'(bus.outSwitch1), 32'd1);
    hold(1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 12);
    check("midrst_repress_counter", 32'(bus.counter), 32'd6);
    hold(1'b0, 1'b0, 10);

    // Random button activity with occasional resets
    run = '{0, 0};
    val = '{0, 0};
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (run[i] == 0) begin
          val[i] = 1'($urandom_range(0, 1));
          run[i] = int'($urandom_range(1, 12));
        end
        run[i]--;
      end
      cyc(val[0], val[1], ($urandom_range(0, 299) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
